// File: rtl/latch_write_sequencer.sv
// latch_write_sequencer: drives a level-sensitive latch bank through setup/open/hold phases and checks the captured word
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid, in_data   upstream word offer; in_ready accepts it (only when idle)
//   latch_data/latch_en registered data and enable driven to the latch bank
//   latch_q             latch output, compared against latch_data at the end of hold
//   busy, done          sequence in progress / one-cycle completion pulse
//   err, err_clr        sticky capture-mismatch flag and its synchronous clear
module latch_write_sequencer #(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] latch_data,
    output logic             latch_en,
    input  logic [WIDTH-1:0] latch_q,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             err_clr
);
    localparam int MAXC = (SETUP_CYC > OPEN_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                                 : ((OPEN_CYC > HOLD_CYC) ? OPEN_CYC : HOLD_CYC);
    localparam int CW = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] OPEN_LD  = CW'(OPEN_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] OPEN  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;

    // Gated by reset so nothing is offered while the block is held in reset.
    assign in_ready = (state == IDLE) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            latch_data <= '0;
            latch_en   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            // A mismatch set later in this block overrides the clear.
            if (err_clr) err <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    latch_data <= in_data;
                    cnt        <= SETUP_LD;
                    busy       <= 1'b1;
                    state      <= SETUP;
                end
                SETUP: if (cnt == '0) begin
                    cnt      <= OPEN_LD;
                    latch_en <= 1'b1;
                    state    <= OPEN;
                end else cnt <= cnt - 1'b1;
                OPEN: if (cnt == '0) begin
                    cnt      <= HOLD_LD;
                    latch_en <= 1'b0;
                    state    <= HOLD;
                end else cnt <= cnt - 1'b1;
                default: if (cnt == '0) begin
                    if (latch_q != latch_data) err <= 1'b1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else cnt <= cnt - 1'b1;
            endcase
        end
    end
endmodule
